// File: rtl/dmem_arbiter_if.sv
// Bus bundle shared by the two requesters, the dmem_arbiter and Data_Memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              MemRW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataW;
  logic [DATA_W-1:0] dataR;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output MemRW, addr, dataW,
    input  dataR
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  MemRW, addr, dataW,
    output dataR
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port Data_Memory with optional ownership lock.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; default is fixed priority to m0.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave arb_io
);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e            state_q;
  logic              last_gnt_q;
  logic              gnt0, gnt1;
  logic              pick1;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Winner of a simultaneous request while idle.
`ifdef DMEM_ARB_RR_EN
  assign pick1 = ~last_gnt_q;
`else
  assign pick1 = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (arb_io.m0_req && arb_io.m1_req) begin
            gnt0 = ~pick1;
            gnt1 = pick1;
          end else begin
            gnt0 = arb_io.m0_req;
            gnt1 = arb_io.m1_req;
          end
        end
        StLock0: gnt0 = arb_io.m0_req;
        StLock1: gnt1 = arb_io.m1_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = arb_io.m0_we;
      mem_addr  = arb_io.m0_addr;
      mem_wdata = arb_io.m0_wdata;
    end else if (gnt1) begin
      mem_we    = arb_io.m1_we;
      mem_addr  = arb_io.m1_addr;
      mem_wdata = arb_io.m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      rvalid0_q <= gnt0 & ~arb_io.m0_we;
      rvalid1_q <= gnt1 & ~arb_io.m1_we;
      if (gnt0 && !arb_io.m0_we) rdata0_q <= arb_io.dataR;
      if (gnt1 && !arb_io.m1_we) rdata1_q <= arb_io.dataR;
      if (gnt0) begin
        last_gnt_q <= 1'b0;
      end else if (gnt1) begin
        last_gnt_q <= 1'b1;
      end
      // A lock survives only while its owner keeps being granted with lock set.
      unique case (state_q)
        StIdle: begin
          if (gnt0 && arb_io.m0_lock) begin
            state_q <= StLock0;
          end else if (gnt1 && arb_io.m1_lock) begin
            state_q <= StLock1;
          end
        end
        StLock0: if (!(gnt0 && arb_io.m0_lock)) state_q <= StIdle;
        StLock1: if (!(gnt1 && arb_io.m1_lock)) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign arb_io.m0_gnt    = gnt0;
  assign arb_io.m1_gnt    = gnt1;
  // Hide a read return that lands in a reset cycle.
  assign arb_io.m0_rvalid = rvalid0_q & ~rst;
  assign arb_io.m1_rvalid = rvalid1_q & ~rst;
  assign arb_io.m0_rdata  = rdata0_q;
  assign arb_io.m1_rdata  = rdata1_q;
  assign arb_io.MemRW     = mem_we;
  assign arb_io.addr      = mem_addr;
  assign arb_io.dataW     = mem_wdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single-port `Data_Memory` between the core load/store path (master 0) and the program/debug loader (master 1). It selects one request per cycle, drives the memory's `MemRW`/`addr`/`dataW` inputs from the winner, and returns registered read data to the winner one cycle later. An optional lock holds ownership across multi-access sequences such as read-modify-write. It sits between the datapath/loader and `Data_Memory` in the top-level core.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req` / `m1_req`  in  1  access request; must be held until granted.
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read.
- `m0_lock` / `m1_lock`  in  1  keep ownership after this access.
- `m0_addr` / `m1_addr`  in  ADDR_W  byte address.
- `m0_wdata` / `m1_wdata`  in  DATA_W  write data.
- `m0_gnt` / `m1_gnt`  out  1  combinational grant; access happens this cycle.
- `m0_rvalid` / `m1_rvalid`  out  1  read data valid, one-cycle pulse.
- `m0_rdata` / `m1_rdata`  out  DATA_W  registered read data.
- `MemRW`  out  1  to `Data_Memory`; 1 = write.
- `addr`  out  ADDR_W  to `Data_Memory`.
- `dataW`  out  DATA_W  to `Data_Memory`.
- `dataR`  in  DATA_W  combinational read data from `Data_Memory`.

## Operation
- FSM states are IDLE, LOCK0 and LOCK1. Reset state is IDLE.
- IDLE arbitration:
  - If exactly one `req` is high, that master is granted.
  - If both are high, the winner follows the policy in Configuration.
- LOCKn: only master n can be granted. The other master's `req` is ignored, so its `gnt` stays 0.
- Transitions:
  - IDLE→LOCKn when master n is granted with `mn_lock`=1.
  - LOCKn→IDLE when master n is granted with `mn_lock`=0, or when `mn_req`=0.
  - LOCKn→LOCKn when master n is granted with `mn_lock`=1.
- Granted master drives the memory: `MemRW`=`mn_we`, `addr`=`mn_addr`, `dataW`=`mn_wdata`.
- No grant: `MemRW`=0, `addr`=0, `dataW`=0. Memory is never written without a grant.
- Granted read: `dataR` is captured into `mn_rdata` at the closing edge, and `mn_rvalid`=1 for the next cycle only.
- Granted write: committed by `Data_Memory` at the closing edge. No `rvalid` is generated.
- `mn_rdata` holds its last value until the next read for master n. It is not cleared when `rvalid` drops.
- `last_gnt` register:
  - Updates on every grant to the granted master index.
  - Resets to 1, so master 0 wins the first conflict.

## Timing
- Grant latency is 0 cycles: `gnt` rises combinationally in the same cycle as an eligible `req`.
- Throughput: one access per cycle.
  - Back-to-back grants to the same master are allowed.
  - Under continuous contention, round-robin alternates grants every cycle.
- Read latency: `rvalid`/`rdata` appear 1 cycle after the granted cycle.
- A read in cycle N and a write to the same address by the other master in cycle N+1: the read returns the old data.
- Reset values: all `gnt`=0, all `rvalid`=0, all `rdata`=0, `MemRW`=0, `addr`=0, `dataW`=0, state IDLE, `last_gnt`=1.
- While `rst`=1:
  - Grants are forced to 0, and memory outputs are forced to their idle values.
  - A pending `rvalid` due in the next cycle is suppressed.
  - Any held lock is dropped.

## Configuration
- `DMEM_ARB_RR_EN`
  - Defined: a conflict in IDLE grants the master that is not `last_gnt` (round-robin).
  - Undefined: master 0 always wins conflicts (fixed priority). `last_gnt` is still maintained but does not affect selection.
  - Lock behaviour is identical in both builds.

## Test plan
- Single write then read, master 0:
  - Stimulus: write `addr`=0x05, `wdata`=0xCACACACA, then read 0x05.
  - Response: `m0_gnt`=1 in both cycles; `m0_rvalid`=1 with `m0_rdata`=0xCACACACA exactly one cycle after the read grant.
- Contention, RR build:
  - Stimulus: both masters read continuously, m0 at 0x05, m1 at 0x1F (preloaded with 0xFEFEFEFE).
  - Response: grants alternate m0, m1, m0, …, starting with m0; each `rvalid` is one cycle after its grant.
- Contention, fixed build:
  - Stimulus: same as the RR contention case.
  - Response: m0 is granted every cycle; `m1_gnt` stays 0 until `m0_req` drops.
- Lock:
  - Stimulus: m0 reads 0x1F with `lock`=1, then writes 0x1F with `lock`=0, with m1 requesting throughout.
  - Response: m1 is blocked for both cycles; state returns to IDLE and m1 is granted in the following cycle.
- Reset mid-operation:
  - Stimulus: assert `rst` in the cycle after a granted read.
  - Response: `rvalid` stays 0; `MemRW`/`addr`/`dataW` are 0; lock is cleared; first post-reset conflict grants m0.
- No request:
  - Stimulus: both `req`=0 for 5 cycles.
  - Response: `MemRW`=0, `addr`=0, and memory contents are unchanged.
